// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the sync_fifo_p slice.
// Optional FWFT mode is selected by SYNC_FIFO_FWFT_EN.
package fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 32;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_p_if.sv
// Write/read handshake and status bundle for sync_fifo_p.
// Same bundle in standard and SYNC_FIFO_FWFT_EN builds.
interface sync_fifo_p_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
);

    localparam int CW = clog2(DEPTH) + 1;

    logic              wr_en;
    logic [DATA_W-1:0] data_in;
    logic              rd_en;
    logic [DATA_W-1:0] data_op;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, data_in, rd_en,
        input  data_op, full, empty, almost_full, almost_empty,
        input  count, overflow, underflow
    );

    modport slave (
        input  wr_en, data_in, rd_en,
        output data_op, full, empty, almost_full, almost_empty,
        output count, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage, synchronous write port.
// Read port is registered, or combinational with SYNC_FIFO_FWFT_EN.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic              clk,
`ifndef SYNC_FIFO_FWFT_EN
    input  logic              rst,
    input  logic              re,
`endif
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rdata = mem[raddr];
`else
    // Output register holds the last popped word between reads.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end
`endif

endmodule

// File: rtl/sync_fifo_p.sv
// Synchronous FIFO with registered flags and sticky error bits.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_p
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AF_TH  = DEPTH - 4,
    parameter int AE_TH  = 4
) (
    input logic         clk,
    input logic         rst,
    sync_fifo_p_if.slave bus
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          full_q;
    logic          empty_q;
    logic          af_q;
    logic          ae_q;
    logic          ovf_q;
    logic          unf_q;
    logic          wr_acc;
    logic          rd_acc;

    // A full FIFO still takes a write when the same cycle pops.
    assign rd_acc = bus.rd_en && !empty_q;
    assign wr_acc = bus.wr_en && (!full_q || bus.rd_en);

    always_comb begin
        cnt_nxt = cnt;
        unique case ({wr_acc, rd_acc})
            2'b10:   cnt_nxt = cnt + CW'(1);
            2'b01:   cnt_nxt = cnt - CW'(1);
            default: cnt_nxt = cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
            cnt     <= cnt_nxt;
            full_q  <= (int'(cnt_nxt) == DEPTH);
            empty_q <= (cnt_nxt == '0);
            af_q    <= (int'(cnt_nxt) >= AF_TH);
            ae_q    <= (int'(cnt_nxt) <= AE_TH);
            if (bus.wr_en && full_q && !bus.rd_en) ovf_q <= 1'b1;
            if (bus.rd_en && empty_q) unf_q <= 1'b1;
        end
    end

    logic [DATA_W-1:0] rdata;

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
`ifndef SYNC_FIFO_FWFT_EN
        .rst   (rst),
        .re    (rd_acc && rst),
`endif
        .we    (wr_acc && rst),
        .waddr (wr_ptr),
        .wdata (bus.data_in),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    assign bus.data_op      = rdata;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.count        = cnt;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_p.sv
// Directed scoreboard bench for sync_fifo_p (DATA_W=8, DEPTH=32).
// Also covers the SYNC_FIFO_FWFT_EN build when that macro is set.
module tb_sync_fifo_p;

    localparam int DW = 8;
    localparam int DP = 32;
    localparam int AF = 28;
    localparam int AE = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_p_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

    sync_fifo_p #(
        .DATA_W (DW),
        .DEPTH  (DP),
        .AF_TH  (AF),
        .AE_TH  (AE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] mdout;
    logic          movf;
    logic          munf;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        int n;
        n = q.size();
        check("count", 32'(bus.count), 32'(n));
        check("full", 32'(bus.full), 32'(n == DP));
        check("empty", 32'(bus.empty), 32'(n == 0));
        check("almost_full", 32'(bus.almost_full), 32'(n >= AF));
        check("almost_empty", 32'(bus.almost_empty), 32'(n <= AE));
        check("overflow", 32'(bus.overflow), 32'(movf));
        check("underflow", 32'(bus.underflow), 32'(munf));
`ifdef SYNC_FIFO_FWFT_EN
        if (n > 0) check("fwft_head", 32'(bus.data_op), 32'(q[0]));
`else
        check("data_op", 32'(bus.data_op), 32'(mdout));
`endif
    endtask

    task automatic step(input logic w, input logic [DW-1:0] d,
                        input logic r);
        bit wa;
        bit ra;
        bus.wr_en   = w;
        bus.data_in = d;
        bus.rd_en   = r;
        wa = w && (q.size() < DP || r);
        ra = r && (q.size() > 0);
        if (w && q.size() == DP && !r) movf = 1'b1;
        if (r && q.size() == 0) munf = 1'b1;
        @(posedge clk);
        if (ra) mdout = q.pop_front();
        if (wa) q.push_back(d);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        check_state();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.wr_en   = 1'b1;
        bus.rd_en   = 1'b1;
        bus.data_in = 8'h3C;
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        q.delete();
        mdout = '0;
        movf  = 1'b0;
        munf  = 1'b0;
        check_state();
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.data_in = '0;
        do_reset();
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_count", 32'(bus.count), 32'd0);

        // Fill 0x00..0x1F, thresholds tracked each step.
        for (int i = 0; i < DP; i++) begin
            step(1'b1, DW'(i), 1'b0);
            if (i + 1 == 5) check("ae_drop", 32'(bus.almost_empty), 32'd0);
            if (i + 1 == AF) check("af_rise", 32'(bus.almost_full), 32'd1);
        end
        check("fill_full", 32'(bus.full), 32'd1);
        check("fill_count", 32'(bus.count), 32'd32);

        step(1'b1, 8'hEE, 1'b0);
        check("ovf_set", 32'(bus.overflow), 32'd1);
        check("ovf_count", 32'(bus.count), 32'd32);

        for (int i = 0; i < DP; i++) step(1'b0, 8'h00, 1'b1);
        check("drain_empty", 32'(bus.empty), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
        check("drain_last", 32'(bus.data_op), 32'h1F);
`endif

        step(1'b0, 8'h00, 1'b1);
        check("unf_set", 32'(bus.underflow), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
        check("unf_hold", 32'(bus.data_op), 32'h1F);
`endif
        step(1'b1, 8'h77, 1'b0);
        step(1'b0, 8'h00, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
        check("unf_ptr", 32'(bus.data_op), 32'h77);
`endif

        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, DW'(8'h80 + i), 1'b0);
        for (int i = 0; i < 100; i++) step(1'b1, DW'(i * 7 + 3), 1'b1);
        check("stream_count", 32'(bus.count), 32'd10);

        do_reset();
        for (int i = 0; i < DP; i++) step(1'b1, DW'(8'h40 + i), 1'b0);
        step(1'b1, 8'hD1, 1'b1);
        check("full_both_cnt", 32'(bus.count), 32'd32);
        check("full_both_ovf", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < DP; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'hB2, 1'b1);
        check("empty_both_cnt", 32'(bus.count), 32'd1);
        check("empty_both_unf", 32'(bus.underflow), 32'd1);
        step(1'b0, 8'h00, 1'b1);

        do_reset();
        for (int i = 0; i < 17; i++) step(1'b1, DW'($urandom_range(0, 255)), 1'b0);
        check("pre_rst_count", 32'(bus.count), 32'd17);
        do_reset();
        check("mid_rst_count", 32'(bus.count), 32'd0);
        check("mid_rst_ae", 32'(bus.almost_empty), 32'd1);
        step(1'b1, 8'hA5, 1'b0);
        check("a5_empty", 32'(bus.empty), 32'd0);
`ifdef SYNC_FIFO_FWFT_EN
        check("a5_fwft", 32'(bus.data_op), 32'hA5);
`endif
        step(1'b0, 8'h00, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
        check("a5_std", 32'(bus.data_op), 32'hA5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_fifo_p.md
SYNC_FIFO_P -- requirements
Module: sync_fifo_p

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 32, number of entries, a power of two and at least 4.
REQ-003 The block SHALL have parameter AF_TH, default DEPTH-4, almost_full threshold in entries.
REQ-004 The block SHALL have parameter AE_TH, default 4, almost_empty threshold in entries.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst, input, 1 bit, synchronous active-low reset.
REQ-007 The block SHALL have port wr_en, input, 1 bit, write request.
REQ-008 The block SHALL have port data_in, input, DATA_W bits, write data.
REQ-009 The block SHALL have port rd_en, input, 1 bit, read request.
REQ-010 The block SHALL have port data_op, output, DATA_W bits, read data.
REQ-011 The block SHALL have ports full and empty, outputs, 1 bit each.
REQ-012 The block SHALL have ports almost_full and almost_empty, outputs, 1 bit each.
REQ-013 The block SHALL have port count, output, log2(DEPTH)+1 bits, current occupancy 0..DEPTH.
REQ-014 The block SHALL have ports overflow and underflow, outputs, 1 bit each, sticky error flags.

Function
REQ-015 A write SHALL be accepted when wr_en=1 and either full=0, or full=1 with rd_en=1 (a read is accepted in the same cycle).
REQ-016 A read SHALL be accepted when rd_en=1 and empty=0; a read and a write requested together on an empty FIFO SHALL accept the write only.
REQ-017 An accepted write SHALL store data_in at wr_ptr; wr_ptr SHALL then increment modulo DEPTH.
REQ-018 An accepted read SHALL increment rd_ptr modulo DEPTH.
REQ-019 count SHALL rise by 1 on a write-only cycle, fall by 1 on a read-only cycle, and stay unchanged on a cycle that accepts both or neither.
REQ-020 Flags SHALL be registered and consistent with count after each edge: full=(count==DEPTH), empty=(count==0), almost_full=(count>=AF_TH), almost_empty=(count<=AE_TH).
REQ-021 overflow SHALL set when wr_en=1 and full=1 and rd_en=0, and SHALL stay set until reset; FIFO contents SHALL be unchanged by the rejected write.
REQ-022 underflow SHALL set when rd_en=1 and empty=1, and SHALL stay set until reset; the pointers SHALL be unchanged by the rejected read.
REQ-023 In standard mode, data_op SHALL present the popped word on the edge after the read is accepted (1-cycle latency), and SHALL hold its value otherwise.
REQ-024 Data order SHALL be strict FIFO across pointer wrap-around, with no loss or duplication at any occupancy.

Reset
REQ-025 While rst=0 at a clk edge, the block SHALL clear wr_ptr, rd_ptr, count, full, almost_full, overflow, underflow and data_op to 0, and set empty and almost_empty to 1.
REQ-026 Reset SHALL take priority over any concurrent read or write, and SHALL discard all stored entries mid-operation; memory contents need not be cleared.

Configuration
REQ-027 When macro SYNC_FIFO_FWFT_EN is defined, the block SHALL operate first-word-fall-through: data_op shows the head entry whenever empty=0, and an accepted read advances to the next entry with 0-cycle latency.
REQ-028 Under SYNC_FIFO_FWFT_EN, a word written into an empty FIFO SHALL appear on data_op on the same edge that empty deasserts, and data_op SHALL be don't-care while empty=1.
REQ-029 When SYNC_FIFO_FWFT_EN is undefined, the block SHALL use the standard mode of REQ-023.

Structure
REQ-030 Package fifo_pkg SHALL hold the default DATA_W and DEPTH values and a pointer-width function clog2.
REQ-031 Storage SHALL be a sub-module fifo_mem: a DEPTH x DATA_W array with one write port (synchronous) and one read port (synchronous in standard mode, combinational under FWFT).

Verification (DATA_W=8, DEPTH=32, AF_TH=28, AE_TH=4)
REQ-032 Reset, then 32 writes of 0x00..0x1F -> full=1 and count=32 on the last edge; almost_full=1 from count=28; almost_empty=0 from count=5.
REQ-033 A 33rd write with rd_en=0 -> overflow=1 and count stays 32; 32 reads -> data 0x00..0x1F in order, empty=1.
REQ-034 rd_en=1 on an empty FIFO -> underflow=1, pointers unchanged, data_op unchanged.
REQ-035 Streaming 100 words with wr_en=rd_en=1 at count=10 -> count stays 10, order preserved across the pointer wrap.
REQ-036 FIFO full with wr_en=rd_en=1 -> both accepted, count=32, overflow=0; empty FIFO with wr_en=rd_en=1 -> count=1, underflow=1.
REQ-037 Reset asserted at count=17 -> next edge gives count=0, empty=1, flags cleared; under SYNC_FIFO_FWFT_EN, a write of 0xA5 to the empty FIFO -> data_op=0xA5 on the edge where empty deasserts.
